// File: rtl/cv32e40p_alu_ft_reconfig_ctrl.sv
// -----------------------------------------------------------------------------
// cv32e40p_alu_ft_reconfig_ctrl
//
// Reconfiguration controller for the fault-tolerant ALU block. Consumes the
// per-ALU permanent-fault pulses from the ALU error counter and drives the
// spare-selection mux and per-ALU clock enables so that three healthy
// replicas vote while the fourth sits clock-gated as a spare. A fault in an
// active replica wakes the spare, lets its input pipe settle for WAKE_CYCLES
// cycles, then swaps it in at the next instruction boundary (ex_ready_i).
//
// Ports:
//   clk                                 core clock
//   rst_n                               asynchronous active-low reset
//   perf_counter_permanent_faulty_alu_i one-cycle fault pulse per ALU
//   ex_ready_i                          instruction boundary marker
//   sel_mux_ex_o                        bit i=1: ALU i feeds voter input i,
//                                       bit i=0: ALU3 feeds voter input i
//   clock_en_o                          per-ALU input-register clock enable
//   faulty_mask_o                       sticky set of ALUs declared faulty
//   reconfig_busy_o                     swap in progress
//   degraded_o                          no healthy spare remains
//   fatal_o                             fewer than three healthy voters (sticky)
// -----------------------------------------------------------------------------
module cv32e40p_alu_ft_reconfig_ctrl #(
   parameter int unsigned WAKE_CYCLES = 2  // 1..15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] perf_counter_permanent_faulty_alu_i,
   input  logic       ex_ready_i,
   output logic [2:0] sel_mux_ex_o,
   output logic [3:0] clock_en_o,
   output logic [3:0] faulty_mask_o,
   output logic       reconfig_busy_o,
   output logic       degraded_o,
   output logic       fatal_o
);

   localparam logic [3:0] LP_CNT_INIT = 4'(WAKE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_NOMINAL,
      S_WAKE,
      S_WAIT_BND,
      S_DEGRADED,
      S_FATAL
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_cnt;
   logic [1:0] r_tgt;

   logic [2:0] r_sel,  w_sel_nxt;
   logic [3:0] r_clk,  w_clk_nxt;
   logic [3:0] r_mask;
   logic       r_busy, w_busy_nxt;
   logic       r_deg,  w_deg_nxt;
   logic       r_fat,  w_fat_nxt;

   logic [3:0] w_new_f;
   logic [3:0] w_active;
   logic [3:0] w_tgt_oh;
   logic       w_multi;
   logic [1:0] w_new_idx;

   assign w_new_f  = perf_counter_permanent_faulty_alu_i & ~r_mask;
   // More than one bit set: clearing the lowest set bit leaves something.
   assign w_multi  = |(w_new_f & (w_new_f - 4'd1));
   assign w_tgt_oh = 4'b0001 << r_tgt;

   // While the spare is being woken all four clocks run, but only ALU0..2
   // are actually voting.
   assign w_active = (r_state == S_WAKE || r_state == S_WAIT_BND) ? 4'b0111 : r_clk;

   always_comb begin
      w_new_idx = 2'd2;
      if (w_new_f[0])      w_new_idx = 2'd0;
      else if (w_new_f[1]) w_new_idx = 2'd1;
   end

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_NOMINAL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_NOMINAL: begin
            if (w_multi)                  w_state_nxt = S_FATAL;
            else if (w_new_f == 4'b1000)  w_state_nxt = S_DEGRADED;
            else if (w_new_f != 4'b0000)  w_state_nxt = S_WAKE;
         end
         S_WAKE: begin
            // tgt is already in the mask, so any new bit is a second fault
            if (|(w_new_f & ~w_tgt_oh))   w_state_nxt = S_FATAL;
            else if (r_cnt == 4'd0)       w_state_nxt = S_WAIT_BND;
         end
         S_WAIT_BND: begin
            // a fault coinciding with the boundary wins over the swap
            if (|(w_new_f & ~w_tgt_oh))   w_state_nxt = S_FATAL;
            else if (ex_ready_i)          w_state_nxt = S_DEGRADED;
         end
         S_DEGRADED: begin
            if (|(w_new_f & w_active))    w_state_nxt = S_FATAL;
         end
         S_FATAL:   w_state_nxt = S_FATAL;
         default:   w_state_nxt = S_FATAL;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      w_sel_nxt  = r_sel;
      w_clk_nxt  = r_clk;
      w_busy_nxt = r_busy;
      w_deg_nxt  = r_deg;
      w_fat_nxt  = r_fat;
      unique case (w_state_nxt)
         S_FATAL: begin
            // mux and clocks freeze where they were
            w_fat_nxt  = 1'b1;
            w_busy_nxt = 1'b0;
            w_deg_nxt  = 1'b1;
         end
         S_WAKE: begin
            if (r_state == S_NOMINAL) begin
               w_clk_nxt  = 4'b1111;
               w_busy_nxt = 1'b1;
            end
         end
         S_DEGRADED: begin
            w_deg_nxt = 1'b1;
            if (r_state == S_WAIT_BND) begin
               w_sel_nxt  = r_sel & ~w_tgt_oh[2:0];
               w_clk_nxt  = 4'b1111 & ~w_tgt_oh;
               w_busy_nxt = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel  <= 3'b111;
         r_clk  <= 4'b0111;
         r_mask <= 4'b0000;
         r_busy <= 1'b0;
         r_deg  <= 1'b0;
         r_fat  <= 1'b0;
         r_cnt  <= 4'd0;
         r_tgt  <= 2'd0;
      end else begin
         r_sel  <= w_sel_nxt;
         r_clk  <= w_clk_nxt;
         r_mask <= r_mask | perf_counter_permanent_faulty_alu_i;
         r_busy <= w_busy_nxt;
         r_deg  <= w_deg_nxt;
         r_fat  <= w_fat_nxt;
         if (r_state == S_NOMINAL && w_state_nxt == S_WAKE) begin
            r_cnt <= LP_CNT_INIT;
            r_tgt <= w_new_idx;
         end else if (r_state == S_WAKE && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   assign sel_mux_ex_o    = r_sel;
   assign clock_en_o      = r_clk;
   assign faulty_mask_o   = r_mask;
   assign reconfig_busy_o = r_busy;
   assign degraded_o      = r_deg;
   assign fatal_o         = r_fat;

endmodule

// File: doc/cv32e40p_alu_ft_reconfig_ctrl.md
Name: cv32e40p_alu_ft_reconfig_ctrl

Overview:
- Consumer end of the fault-tolerant ALU error-reporting path.
- Takes the per-ALU permanent-fault pulses produced by the ALU error counter.
- Drives the spare-selection mux control and per-ALU clock enables back into the fault-tolerant ALU. This keeps three healthy replicas voting and the fourth in clock-gated standby.
- On a permanent fault in an active replica it wakes the spare, waits for its input pipe to settle, and swaps the spare in at an instruction boundary.

Parameters:
- WAKE_CYCLES, 2, cycles the spare stays clock-enabled before the swap (range 1..15).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- perf_counter_permanent_faulty_alu_i  in  4  one-cycle pulse per ALU; bit k means ALU k was declared permanently faulty
- ex_ready_i  in  1  EX stage ready; a high value marks an instruction boundary where the swap is allowed
- sel_mux_ex_o  out  3  bit i=1 selects ALU i into voter input i; bit i=0 selects ALU3
- clock_en_o  out  4  per-ALU input-register clock enable
- faulty_mask_o  out  4  sticky record of ALUs declared faulty
- reconfig_busy_o  out  1  high while a swap is in progress (WAKE or WAIT_BND)
- degraded_o  out  1  no healthy spare remains
- fatal_o  out  1  three healthy voting replicas are no longer available; sticky

Behaviour:
- All outputs are registered.
- Reset values: sel_mux_ex_o=3'b111, clock_en_o=4'b0111, faulty_mask_o=0, reconfig_busy_o=0, degraded_o=0, fatal_o=0, state=NOMINAL.
- Assertion of rst_n in any state, including mid-swap, returns to the reset values asynchronously.
- Fault intake:
  - new_f = pulse & ~faulty_mask_o.
  - faulty_mask_o |= pulse every cycle, in every state.
  - Pulses for ALUs already in the mask are ignored.
- Active set: ALUs k with clock_en_o[k]=1, excluding the spare during WAKE/WAIT_BND.
- Legal steady configurations (sel/clk): 111/0111 (ALU3 spare), 110/1110 (ALU0 out), 101/1101 (ALU1 out), 011/1011 (ALU2 out).
- State NOMINAL (ALU3 is spare and healthy):
  - new_f == 0: stay.
  - new_f == 4'b1000 only: go to DEGRADED; configuration unchanged; degraded_o=1 next cycle.
  - Exactly one active bit k in {0,1,2} and bit3 clear: latch tgt=k, load counter=WAKE_CYCLES-1, set clock_en_o=4'b1111 and reconfig_busy_o=1 next cycle, go to WAKE.
  - Two or more new bits (any combination): go to FATAL.
- State WAKE:
  - Counter decrements each cycle.
  - At counter==0, go to WAIT_BND.
  - The spare is therefore clocked for exactly WAKE_CYCLES cycles before WAIT_BND is entered.
- State WAIT_BND:
  - Hold clock_en_o=1111 until ex_ready_i=1.
  - In that cycle: sel_mux_ex_o[tgt]=0, clock_en_o[tgt]=0, reconfig_busy_o=0, degraded_o=1 (all visible next cycle); go to DEGRADED.
  - If ex_ready_i stays low, wait indefinitely; no timeout.
- Fault during WAKE/WAIT_BND:
  - A new bit for ALU3 or for any active ALU other than tgt goes to FATAL immediately, aborting the swap.
  - A repeat for tgt is ignored.
- State DEGRADED:
  - A new bit for an active ALU goes to FATAL.
  - A new bit for the gated ALU only updates the mask.
- State FATAL:
  - fatal_o=1, reconfig_busy_o=0, degraded_o=1.
  - sel_mux_ex_o is held at its last value; clock_en_o is held at its last value.
  - FATAL is left only by reset.
- Priority: reset > FATAL entry > swap completion.
- A swap-completing ex_ready_i coinciding with a new active fault goes to FATAL; no swap is applied.
- Counter width is 4 bits; no wrap, because the counter reloads only on WAKE entry.

Test Plan:
- Reset then idle 20 cycles -> sel=111, clk=0111, mask=0, all flags 0.
- Pulse bit1, WAKE_CYCLES=2, ex_ready_i high -> clk=1111 and busy=1 for 2 cycles plus 1 WAIT_BND cycle; then sel=101, clk=1101, degraded=1, busy=0, mask=0010.
- Pulse bit0, hold ex_ready_i low 10 cycles in WAIT_BND, then raise it -> clk stays 1111 and sel stays 111 throughout; swap to sel=110, clk=1110 the cycle after ex_ready_i rises.
- Pulse bit3 in NOMINAL -> sel/clk unchanged, degraded=1, mask=1000; a later pulse on bit2 -> fatal=1, config held.
- Simultaneous pulse 4'b0101 -> fatal=1 next cycle, mask=0101, sel=111, clk=0111; repeat pulses cause no change.
- Pulse bit2, then pulse bit0 during WAKE, then assert rst_n low mid-FATAL -> fatal=1 with clk=1111; after reset all outputs return to reset values.
